// File: rtl/counter_checker_pkg.sv
// rtl/counter_checker_pkg.sv - shared state type and helpers for counter_checker
package counter_checker_pkg;

   // Checker state: waiting for a first observed clear, or locked to the counter
   typedef enum logic {
      UNSYNC = 1'b0,
      TRACK  = 1'b1
   } state_t;

   // Largest value representable in w bits, used as the saturation ceiling
   function automatic longint unsigned sat_max(input int unsigned w);
      if (w >= 64) begin
         return '1;
      end
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/counter_checker_wdog.sv
// rtl/counter_checker_wdog.sv - idle-enable run counter and stall pulse (COUNTER_CHECKER_WDOG_EN builds)
module counter_checker_wdog
   import counter_checker_pkg::*;
#(
   parameter int WDOG_CYC = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic track,
   input  logic clear_act,
   input  logic cnt_en,
   output logic stall
);

   localparam int RUN_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(WDOG_CYC - 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   logic [RUN_W-1:0] run;

   // Count consecutive idle samples while tracking; pulse stall on the last one and restart
   always_ff @(posedge clk) begin
      if (clr || !track || clear_act || cnt_en) begin
         run   <= '0;
         stall <= 1'b0;
      end else if (run == RUN_LAST) begin
         run   <= '0;
         stall <= 1'b1;
      end else begin
         run   <= run + RUN_ONE;
         stall <= 1'b0;
      end
   end

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive checker for a 4-bit clear/enable up counter; watchdog under COUNTER_CHECKER_WDOG_EN
module counter_checker
   import counter_checker_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit CLR_POL   = 1'b0,
   parameter int ERR_CNT_W = 8,
   parameter int WDOG_CYC  = 16
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 cnt_clr,
   input  logic                 cnt_en,
   input  logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     expected,
   output logic                 synced,
   output logic                 err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 wrap,
   output logic                 stall
);

   localparam logic [WIDTH-1:0]     CNT_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0]     CNT_TOP  = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = ERR_CNT_W'(sat_max($unsigned(ERR_CNT_W)));

   // Next counter value from a given current value and the sampled controls
   function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] v,
                                                input logic             clear_a,
                                                input logic             en);
      if (clear_a) begin
         return '0;
      end else if (en) begin
         return v + CNT_ONE;
      end
      return v;
   endfunction

   state_t state;

   logic             clear_act;
   logic             mismatch;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] next_exp;
   logic             next_wrap;

   assign clear_act = (cnt_clr == CLR_POL);
   assign mismatch  = (state == TRACK) && (q != expected);
   // After a mismatch the observed value is trusted, so one bad sample costs one error
   assign base      = mismatch ? q : expected;
   assign next_exp  = predict(base, clear_act, cnt_en);
   // Rollover only counts when enable carries all-ones to zero, never on clear
   assign next_wrap = !clear_act && cnt_en && (base == CNT_TOP);
   assign synced    = (state == TRACK);

   // FSM and prediction register: lock on the first active clear, then follow the counter
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= UNSYNC;
         expected <= '0;
      end else if (state == UNSYNC) begin
         if (clear_act) begin
            state    <= TRACK;
            expected <= '0;
         end
      end else begin
         expected <= next_exp;
      end
   end

   // One-cycle err and wrap pulses from the compare at this edge
   always_ff @(posedge clk) begin
      if (clr || state == UNSYNC) begin
         err  <= 1'b0;
         wrap <= 1'b0;
      end else begin
         err  <= mismatch;
         wrap <= next_wrap;
      end
   end

   // Sticky flag and saturating mismatch tally
   always_ff @(posedge clk) begin
      if (clr) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (mismatch) begin
         err_sticky <= 1'b1;
         if (err_count != ERR_MAX) begin
            err_count <= err_count + ERR_ONE;
         end
      end
   end

`ifdef COUNTER_CHECKER_WDOG_EN
   counter_checker_wdog #(
      .WDOG_CYC (WDOG_CYC)
   ) u_wdog (
      .clk       (clk),
      .clr       (clr),
      .track     (state == TRACK),
      .clear_act (clear_act),
      .cnt_en    (cnt_en),
      .stall     (stall)
   );
`else
   logic unused_wdog;
   assign unused_wdog = (WDOG_CYC != 0);
   assign stall       = 1'b0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed self-checking bench for counter_checker
module tb_counter_checker;

   logic       clk = 1'b0;
   logic       clr;
   logic       cnt_clr;
   logic       cnt_en;
   logic [3:0] q;
   logic [3:0] expected;
   logic       synced;
   logic       err;
   logic       err_sticky;
   logic [7:0] err_count;
   logic       wrap;
   logic       stall;

   int         n_chk = 0;
   int         n_err = 0;
   logic [3:0] cm;

   counter_checker #(
      .WIDTH     (4),
      .CLR_POL   (1'b0),
      .ERR_CNT_W (8),
      .WDOG_CYC  (16)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .cnt_clr    (cnt_clr),
      .cnt_en     (cnt_en),
      .q          (q),
      .expected   (expected),
      .synced     (synced),
      .err        (err),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .wrap       (wrap),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   // Present raw inputs, let one edge pass, return 1 time unit later
   task automatic drive(input logic c, input logic e, input logic [3:0] qv);
      cnt_clr = c;
      cnt_en  = e;
      q       = qv;
      @(posedge clk);
      #1;
   endtask

   // One cycle of a well-behaved counter; clear is active low here
   task automatic cstep(input logic clear_a, input logic e);
      drive(clear_a ? 1'b0 : 1'b1, e, cm);
      if (clear_a) cm = 4'd0;
      else if (e)  cm = cm + 4'd1;
   endtask

   initial begin
      int err_hits;
      int wrap_hits;
      int wrap_at;
      int stall_hits;
      int stall_at;

      clr = 1'b1;
      cm  = 4'd0;
      drive(1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b0, 4'd0);
      check("rst_expected", expected, 0);
      check("rst_synced", synced, 0);
      check("rst_err", err, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_count", err_count, 0);
      check("rst_wrap", wrap, 0);
      check("rst_stall", stall, 0);
      clr = 1'b0;

      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         check("unsync_synced", synced, 0);
         check("unsync_count", err_count, 0);
         check("unsync_err", err, 0);
      end

      cstep(1'b1, 1'b0);
      check("sync_rise", synced, 1);
      check("sync_expected", expected, 0);
      cstep(1'b1, 1'b0);
      cstep(1'b1, 1'b0);

      err_hits  = 0;
      wrap_hits = 0;
      wrap_at   = 0;
      for (int k = 1; k <= 20; k++) begin
         cstep(1'b0, 1'b1);
         if (err === 1'b1) err_hits++;
         if (wrap === 1'b1) begin
            wrap_hits++;
            wrap_at = k;
         end
         check("count_expected", expected, k % 16);
      end
      check("count_no_err", err_hits, 0);
      check("count_wrap_hits", wrap_hits, 1);
      check("count_wrap_at", wrap_at, 16);
      check("count_synced", synced, 1);

      drive(1'b1, 1'b1, 4'd5);
      cm = 4'd6;
      check("glitch_err", err, 1);
      check("glitch_count", err_count, 1);
      check("glitch_sticky", err_sticky, 1);
      check("glitch_expected", expected, 6);
      for (int k = 0; k < 3; k++) begin
         cstep(1'b0, 1'b1);
         check("post_glitch_err", err, 0);
      end
      check("post_glitch_count", err_count, 1);
      check("post_glitch_sticky", err_sticky, 1);
      check("pre_clr_en_expected", expected, 9);

      cstep(1'b1, 1'b1);
      check("clr_en_expected", expected, 0);
      check("clr_en_wrap", wrap, 0);
      check("clr_en_err", err, 0);
      check("clr_en_synced", synced, 1);

      drive(1'b1, 1'b1, 4'd15);
      cm = 4'd0;
      check("mm_wrap_err", err, 1);
      check("mm_wrap_wrap", wrap, 1);
      check("mm_wrap_expected", expected, 0);
      check("mm_wrap_count", err_count, 2);

      drive(1'b1, 1'b0, 4'd15);
      cm = 4'd15;
      check("top_expected", expected, 15);
      check("top_count", err_count, 3);
      cstep(1'b1, 1'b1);
      check("clr_top_expected", expected, 0);
      check("clr_top_wrap", wrap, 0);
      check("clr_top_err", err, 0);

      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0, (i % 2 == 1) ? 4'd2 : 4'd1);
         if (i == 99) check("sat_mid_count", err_count, 103);
      end
      check("sat_count", err_count, 255);
      check("sat_err", err, 1);
      check("sat_sticky", err_sticky, 1);

      clr = 1'b1;
      drive(1'b1, 1'b0, 4'd7);
      clr = 1'b0;
      check("clr_count", err_count, 0);
      check("clr_sticky", err_sticky, 0);
      check("clr_synced", synced, 0);
      check("clr_err", err, 0);
      check("clr_expected", expected, 0);
      check("clr_wrap", wrap, 0);

      cm = 4'd3;
      cstep(1'b1, 1'b0);
      check("resync_synced", synced, 1);
      stall_hits = 0;
      stall_at   = 0;
      err_hits   = 0;
      for (int k = 1; k <= 18; k++) begin
         cstep(1'b0, 1'b0);
         if (err === 1'b1) err_hits++;
         if (stall === 1'b1) begin
            stall_hits++;
            stall_at = k;
         end
      end
      check("idle_no_err", err_hits, 0);
`ifdef COUNTER_CHECKER_WDOG_EN
      check("stall_hits", stall_hits, 1);
      check("stall_at", stall_at, 16);
`else
      check("stall_hits", stall_hits, 0);
      check("stall_at", stall_at, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
